// File: rtl/icache_pkg.sv
// Shared types and geometry for the 4-way, 8-set, 32-byte-line instruction cache.
package icache_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned TAG_W      = 24;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned SETS       = 8;
  localparam int unsigned WAYS       = 4;
  localparam int unsigned WAY_W      = 2;
  localparam int unsigned LINE_WORDS = 8;
  localparam int unsigned WORD_IDX_W = 3;
  localparam int unsigned LINE_W     = LINE_WORDS * DATA_W;

  // Byte-address field positions: {tag, index, word, byte}
  localparam int unsigned TAG_LSB    = 8;
  localparam int unsigned IDX_LSB    = 5;
  localparam int unsigned WORD_LSB   = 2;

  typedef enum logic [2:0] {
    S_WAIT   = 3'd0,
    S_TAG_RD = 3'd1,
    S_RESP   = 3'd2,
    S_MEM_RD = 3'd3,
    S_RECV   = 3'd4,
    S_REFILL = 3'd5
  } state_e;

endpackage

// File: rtl/icache_victim_sel.sv
// Refill victim choice: lowest invalid way, else the set's round-robin pointer.
module icache_victim_sel
  import icache_pkg::*;
(
  input  logic [WAYS-1:0]  i_valid,
  input  logic [WAY_W-1:0] i_rr,
  output logic [WAY_W-1:0] o_victim_c
);

  always_comb begin
    o_victim_c = i_rr;
    if (!i_valid[0]) begin
      o_victim_c = 2'd0;
    end else if (!i_valid[1]) begin
      o_victim_c = 2'd1;
    end else if (!i_valid[2]) begin
      o_victim_c = 2'd2;
    end else if (!i_valid[3]) begin
      o_victim_c = 2'd3;
    end
  end

endmodule

// File: rtl/tag_array.sv
// One cache way's tag store: synchronous write, asynchronous read, per-set valid bits.
module tag_array #(
  parameter int unsigned TAG_W = 24,
  parameter int unsigned IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] i_idx,
  input  logic             i_wen,
  input  logic [TAG_W-1:0] i_wtag,
  output logic [TAG_W-1:0] o_rtag_c,
  output logic             o_rvalid_c
);

  localparam int unsigned N_SETS = 1 << IDX_W;

  logic [N_SETS-1:0] r_valid;
  logic [TAG_W-1:0]  r_tag [N_SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wen) begin
      r_valid[i_idx] <= 1'b1;
    end
  end

  // Tag storage needs no reset; the valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (i_wen && !rst) begin
      r_tag[i_idx] <= i_wtag;
    end
  end

  assign o_rtag_c   = r_tag[i_idx];
  assign o_rvalid_c = r_valid[i_idx];

endmodule

// File: rtl/icache_ctrl.sv
// Read-only 4-way set-associative I-cache controller: lookup, victim choice,
// 8-beat line refill and single-word CPU response.
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned TAG_W  = 24,
  parameter int unsigned IDX_W  = 3,
  parameter int unsigned WAYS   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              from_cpu_inst_req_valid,
  input  logic [ADDR_W-1:0] from_cpu_inst_req_addr,
  output logic              to_cpu_inst_req_ready,
  output logic              to_cpu_cache_rsp_valid,
  output logic [DATA_W-1:0] to_cpu_cache_rsp_data,
  input  logic              from_cpu_cache_rsp_ready,
  output logic              to_mem_rd_req_valid,
  output logic [ADDR_W-1:0] to_mem_rd_req_addr,
  input  logic              from_mem_rd_req_ready,
  input  logic              from_mem_rd_rsp_valid,
  input  logic [DATA_W-1:0] from_mem_rd_rsp_data,
  input  logic              from_mem_rd_rsp_last,
  output logic              to_mem_rd_rsp_ready
);

  localparam int unsigned N_SETS = 1 << IDX_W;

  state_e                r_state;
  state_e                w_next;

  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [WORD_IDX_W-1:0] r_word;
  logic [WORD_IDX_W-1:0] r_beat_cnt;
  logic [DATA_W-1:0]     r_buf  [LINE_WORDS];
  logic [LINE_W-1:0]     r_line [WAYS][N_SETS];
  logic [WAY_W-1:0]      r_rr   [N_SETS];
  logic [DATA_W-1:0]     r_rsp_data;

  logic [TAG_W-1:0]      w_rtag [WAYS];
  logic [WAYS-1:0]       w_rvalid;
  logic [WAYS-1:0]       w_hit;
  logic [WAYS-1:0]       w_tag_wen;
  logic [WAY_W-1:0]      w_hit_way;
  logic [WAY_W-1:0]      w_victim;
  logic                  w_any_hit;
  logic                  w_req_acc;
  logic                  w_beat_acc;
  logic                  w_refill;
  logic [LINE_W-1:0]     w_fill_line;
  logic                  w_unused;

  // Byte-offset bits are irrelevant for word-aligned fetches.
  assign w_unused = &{1'b0, from_cpu_inst_req_addr[WORD_LSB-1:0]};

  genvar gw;
  generate
    for (gw = 0; gw < WAYS; gw++) begin : g_way
      tag_array #(
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
      ) u_tag (
        .clk        (clk),
        .rst        (rst),
        .i_idx      (r_idx),
        .i_wen      (w_tag_wen[gw]),
        .i_wtag     (r_tag),
        .o_rtag_c   (w_rtag[gw]),
        .o_rvalid_c (w_rvalid[gw])
      );
      assign w_hit[gw] = w_rvalid[gw] && (w_rtag[gw] == r_tag);
    end
  endgenerate

  icache_victim_sel u_victim_sel (
    .i_valid    (w_rvalid),
    .i_rr       (r_rr[r_idx]),
    .o_victim_c (w_victim)
  );

  assign w_any_hit  = |w_hit;
  assign w_req_acc  = (r_state == S_WAIT) && from_cpu_inst_req_valid;
  assign w_beat_acc = (r_state == S_RECV) && from_mem_rd_rsp_valid;
  assign w_refill   = (r_state == S_REFILL) && !rst;

  // Multiple hits are illegal; resolve toward the lowest way.
  always_comb begin
    w_hit_way = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_hit_way = WAY_W'(i);
      end
    end
  end

  always_comb begin
    w_tag_wen = '0;
    if (w_refill) begin
      w_tag_wen[w_victim] = 1'b1;
    end
  end

  always_comb begin
    w_fill_line = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      w_fill_line[i*DATA_W +: DATA_W] = r_buf[i];
    end
  end

  // Next state and handshake outputs, all decoded from the state register.
  always_comb begin
    w_next                 = r_state;
    to_cpu_inst_req_ready  = 1'b0;
    to_cpu_cache_rsp_valid = 1'b0;
    to_mem_rd_req_valid    = 1'b0;
    to_mem_rd_rsp_ready    = 1'b0;
    unique case (r_state)
      S_WAIT: begin
        to_cpu_inst_req_ready = 1'b1;
        if (from_cpu_inst_req_valid) w_next = S_TAG_RD;
      end
      S_TAG_RD: begin
        w_next = w_any_hit ? S_RESP : S_MEM_RD;
      end
      S_MEM_RD: begin
        to_mem_rd_req_valid = 1'b1;
        if (from_mem_rd_req_ready) w_next = S_RECV;
      end
      S_RECV: begin
        to_mem_rd_rsp_ready = 1'b1;
        if (from_mem_rd_rsp_valid && from_mem_rd_rsp_last) w_next = S_REFILL;
      end
      S_REFILL: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        to_cpu_cache_rsp_valid = 1'b1;
        if (from_cpu_cache_rsp_ready) w_next = S_WAIT;
      end
      default: begin
        w_next = S_WAIT;
      end
    endcase
    if (rst) begin
      to_cpu_inst_req_ready  = 1'b0;
      to_cpu_cache_rsp_valid = 1'b0;
      to_mem_rd_req_valid    = 1'b0;
      to_mem_rd_rsp_ready    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_WAIT;
      r_tag      <= '0;
      r_idx      <= '0;
      r_word     <= '0;
      r_beat_cnt <= '0;
      r_rsp_data <= '0;
      for (int s = 0; s < N_SETS; s++) begin
        r_rr[s] <= '0;
      end
    end else begin
      r_state <= w_next;
      if (w_req_acc) begin
        r_tag  <= from_cpu_inst_req_addr[TAG_LSB +: TAG_W];
        r_idx  <= from_cpu_inst_req_addr[IDX_LSB +: IDX_W];
        r_word <= from_cpu_inst_req_addr[WORD_LSB +: WORD_IDX_W];
      end
      if ((r_state == S_TAG_RD) && w_any_hit) begin
        r_rsp_data <= r_line[w_hit_way][r_idx][r_word*DATA_W +: DATA_W];
      end
      // A short burst must not skew the slot numbering of the next refill.
      if (w_beat_acc) begin
        r_beat_cnt <= from_mem_rd_rsp_last ? '0 : r_beat_cnt + WORD_IDX_W'(1);
      end
      if (r_state == S_REFILL) begin
        r_rsp_data  <= r_buf[r_word];
        r_rr[r_idx] <= r_rr[r_idx] + WAY_W'(1);
      end
    end
  end

  // Refill buffer and line storage carry no reset; tag valid bits qualify them.
  always_ff @(posedge clk) begin
    if (w_beat_acc && !rst) begin
      r_buf[r_beat_cnt] <= from_mem_rd_rsp_data;
    end
    if (w_refill) begin
      r_line[w_victim][r_idx] <= w_fill_line;
    end
  end

  assign to_cpu_cache_rsp_data = r_rsp_data;
  assign to_mem_rd_req_addr    = {r_tag, r_idx, {IDX_LSB{1'b0}}};

endmodule
